// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and single-pulse key report
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_row_in     keypad rows, active-low, asynchronous to i_clk
//   o_col_out    column drive, active-low one-hot (1110 = column 0)
//   o_key_code   last accepted key, 4*row + col
//   o_key_valid  one-cycle pulse when a press is accepted
//   o_key_held   high while the accepted key has not been released
module keypad_scan #(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 10
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_row_in,
   output logic [3:0] o_col_out,
   output logic [3:0] o_key_code,
   output logic       o_key_valid,
   output logic       o_key_held
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_SCAN = 2'd0;
   localparam logic [1:0] S_DEB  = 2'd1;
   localparam logic [1:0] S_HELD = 2'd2;

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [DW-1:0] r_div;
   logic [1:0]    r_state;
   logic [1:0]    r_col;
   logic [1:0]    r_crow;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_col_out;
   logic [3:0]    r_key_code;
   logic          r_key_valid;
   logic          r_key_held;

   logic          w_tick;
   logic          w_any_low;
   logic [1:0]    w_win_row;
   logic          w_crow_low;
   logic [CW-1:0] w_cnt_inc;
   logic [1:0]    w_col_next;
   logic [3:0]    w_col_next_drive;

   assign w_tick           = (r_div == DIV_LAST);
   assign w_any_low        = (r_sync2 != 4'hF);
   assign w_crow_low       = ~r_sync2[r_crow];
   assign w_cnt_inc        = r_cnt + CNT_ONE;
   assign w_col_next       = r_col + 2'd1;
   assign w_col_next_drive = ~(4'b0001 << w_col_next);

   // Lowest-index low row wins; row 3 is the fall-through when only it is low.
   always_comb begin
      w_win_row = 2'd3;
      if (!r_sync2[0])      w_win_row = 2'd0;
      else if (!r_sync2[1]) w_win_row = 2'd1;
      else if (!r_sync2[2]) w_win_row = 2'd2;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1     <= 4'hF;
         r_sync2     <= 4'hF;
         r_div       <= '0;
         r_state     <= S_SCAN;
         r_col       <= 2'd0;
         r_crow      <= 2'd0;
         r_cnt       <= '0;
         r_col_out   <= 4'b1110;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_sync1     <= i_row_in;
         r_sync2     <= r_sync1;
         r_key_valid <= 1'b0;
         r_div       <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            case (r_state)
               S_SCAN: begin
                  if (!w_any_low) begin
                     r_col     <= w_col_next;
                     r_col_out <= w_col_next_drive;
                  end else begin
                     r_crow <= w_win_row;
                     // A single-sample debounce accepts on the detecting tick.
                     if (DEBOUNCE == 1) begin
                        r_key_code  <= {w_win_row, r_col};
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_HELD;
                     end else begin
                        r_cnt   <= CNT_ONE;
                        r_state <= S_DEB;
                     end
                  end
               end
               S_DEB: begin
                  if (w_crow_low) begin
                     if (w_cnt_inc == CNT_DONE) begin
                        r_key_code  <= {r_crow, r_col};
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_HELD;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_state   <= S_SCAN;
                     r_col     <= w_col_next;
                     r_col_out <= w_col_next_drive;
                  end
               end
               S_HELD: begin
                  // Release needs DEBOUNCE consecutive high samples; any low restarts it.
                  if (!w_crow_low) begin
                     if (w_cnt_inc == CNT_DONE) begin
                        r_key_held <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_SCAN;
                        r_col      <= w_col_next;
                        r_col_out  <= w_col_next_drive;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_cnt <= '0;
                  end
               end
               default: r_state <= S_SCAN;
            endcase
         end
      end
   end

   assign o_col_out   = r_col_out;
   assign o_key_code  = r_key_code;
   assign o_key_valid = r_key_valid;
   assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with a keypad matrix model
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_row_in    (row_in),
      .o_col_out   (col_out),
      .o_key_code  (key_code),
      .o_key_valid (key_valid),
      .o_key_held  (key_held)
   );

   // Physical keypad: a pressed key pulls its row low while its column is driven.
   logic       pressed [4][4];
   logic [3:0] kp_rows;
   initial begin
      row_in = 4'hF;
      forever begin
         @(negedge clk);
         kp_rows = 4'hF;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (pressed[r][c] && (col_out[c] === 1'b0)) kp_rows[r] = 1'b0;
         row_in = kp_rows;
      end
   end

   // Reference model, tick-level: what rs looks like, when ticks fall, and what each tick decides.
   logic [3:0] m_h1, m_h2, m_rs;
   int         m_n, m_mode, m_col, m_row, m_run, m_low;
   logic [3:0] m_code;
   logic       m_valid, m_held;
   bit         m_ok = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_h1 = 4'hF; m_h2 = 4'hF; m_n = 0; m_mode = 0; m_col = 0; m_row = 0; m_run = 0;
         m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0; m_ok = 1;
      end else begin
         m_rs = m_h2;
         m_h2 = m_h1;
         m_h1 = row_in;
         m_valid = 1'b0;
         if (m_n % SD == SD - 1) begin
            m_low = -1;
            for (int r = 3; r >= 0; r--) if (!m_rs[r]) m_low = r;
            if (m_mode == 0) begin
               if (m_low < 0) m_col = (m_col + 1) % 4;
               else begin
                  m_row = m_low; m_run = 1; m_mode = 1;
               end
            end else if (m_mode == 1) begin
               if (!m_rs[m_row]) m_run = m_run + 1;
               else begin
                  m_mode = 0; m_col = (m_col + 1) % 4;
               end
            end else begin
               m_run = m_rs[m_row] ? m_run + 1 : 0;
               if (m_run >= DB) begin
                  m_held = 1'b0; m_mode = 0; m_run = 0; m_col = (m_col + 1) % 4;
               end
            end
            if (m_mode == 1 && m_run >= DB) begin
               m_code = 4'(4 * m_row + m_col); m_valid = 1'b1; m_held = 1'b1;
               m_mode = 2; m_run = 0;
            end
         end
         m_n = m_n + 1;
      end
   end

   // Literal-check requests from the stimulus, serviced by the compare process.
   string req_name;
   int    req_act, req_exp;
   int    req_seq = 0;
   int    done_seq = 0;

   int         n_tests = 0;
   int         n_fail = 0;
   int         pulse_cnt = 0;
   logic [3:0] last_code = 4'd0;
   logic [3:0] exp_col;

   always @(negedge clk) begin
      if (m_ok) begin
         exp_col = 4'hF ^ (4'b0001 << m_col);
         n_tests++;
         if (col_out !== exp_col || key_code !== m_code || key_valid !== m_valid || key_held !== m_held) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t col_out=%b req %b, key_code=%0d req %0d, key_valid=%b req %b, key_held=%b req %b",
                     $time, col_out, exp_col, key_code, m_code, key_valid, m_valid, key_held, m_held);
         end
         if (key_valid === 1'b1) begin
            pulse_cnt++;
            last_code = key_code;
         end
      end
      if (req_seq != done_seq) begin
         n_tests++;
         if (req_act != req_exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", req_name, req_act, req_exp);
         end
         done_seq = req_seq;
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      req_name = name; req_act = act; req_exp = exp; req_seq++;
      @(negedge clk); #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic wait_pulse(input string name, input int limit);
      int start, k;
      start = pulse_cnt; k = 0;
      while (pulse_cnt == start && k < limit) begin @(negedge clk); #1; k++; end
      if (pulse_cnt == start) lit(name, 0, 1);
   endtask

   task automatic wait_col_value(input string name, input logic [3:0] v, input int limit);
      int k;
      k = 0;
      while (col_out !== v && k < limit) begin @(negedge clk); #1; k++; end
      if (col_out !== v) lit(name, 0, 1);
   endtask

   task automatic wait_col_change(input string name, output logic [3:0] v);
      logic [3:0] old;
      int k;
      old = col_out; k = 0;
      while (col_out === old && k < 40) begin @(negedge clk); #1; k++; end
      if (col_out === old) lit(name, 0, 1);
      v = col_out;
   endtask

   logic [3:0] samp [17];
   logic [3:0] r_col, r_code, v;
   logic       r_valid, r_held;
   int         p0;
   logic       bounce [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;

      // Reset state and idle column rotation, sampled once per cycle.
      r_col = col_out; r_code = key_code; r_valid = key_valid; r_held = key_held;
      samp[0] = col_out;
      for (int k = 1; k < 17; k++) begin @(negedge clk); #1; samp[k] = col_out; end
      lit("reset_col_out", r_col, 4'b1110);
      lit("reset_key_code", r_code, 0);
      lit("reset_key_valid", r_valid, 0);
      lit("reset_key_held", r_held, 0);
      lit("idle_col_k3", samp[3], 4'b1110);
      lit("idle_col_k4", samp[4], 4'b1101);
      lit("idle_col_k7", samp[7], 4'b1101);
      lit("idle_col_k8", samp[8], 4'b1011);
      lit("idle_col_k12", samp[12], 4'b0111);
      lit("idle_col_k16", samp[16], 4'b1110);
      lit("idle_no_pulse", pulse_cnt, 0);

      // Held press of key 6 (row 1, column 2).
      p0 = pulse_cnt;
      pressed[1][2] = 1'b1;
      wait_pulse("timeout_s2_pulse", 200);
      lit("s2_code", last_code, 6);
      lit("s2_held", key_held, 1);
      cycles(40);
      lit("s2_col_frozen", col_out, 4'b1011);
      lit("s2_one_pulse", pulse_cnt - p0, 1);
      lit("s2_still_held", key_held, 1);
      pressed[1][2] = 1'b0;
      cycles(24);
      lit("s2_released", key_held, 0);

      // Press lasting only two ticks: rejected, scan moves on to column 3.
      wait_col_value("timeout_s3_col2", 4'b1011, 40);
      p0 = pulse_cnt;
      pressed[1][2] = 1'b1;
      cycles(6);
      pressed[1][2] = 1'b0;
      wait_col_change("timeout_s3_resume", v);
      lit("s3_resume_col", v, 4'b0111);
      lit("s3_no_pulse", pulse_cnt - p0, 0);

      // Rows 0 and 2 on column 3: row 0 first, then row 2 after row 0 releases.
      p0 = pulse_cnt;
      pressed[0][3] = 1'b1;
      pressed[2][3] = 1'b1;
      wait_pulse("timeout_s4_first", 200);
      lit("s4_first_code", last_code, 3);
      pressed[0][3] = 1'b0;
      wait_pulse("timeout_s4_second", 200);
      lit("s4_second_code", last_code, 11);
      lit("s4_two_pulses", pulse_cnt - p0, 2);
      pressed[2][3] = 1'b0;
      cycles(30);
      lit("s4_released", key_held, 0);

      // Bouncy release: only the final run of three high ticks releases.
      p0 = pulse_cnt;
      pressed[1][2] = 1'b1;
      wait_pulse("timeout_s5_pulse", 200);
      for (int s = 0; s < 6; s++) begin
         pressed[1][2] = bounce[s];
         cycles(SD);
      end
      lit("s5_held_mid_bounce", key_held, 1);
      cycles(20);
      lit("s5_released", key_held, 0);
      lit("s5_one_pulse", pulse_cnt - p0, 1);

      // Reset during HELD aborts silently.
      pressed[1][2] = 1'b1;
      wait_pulse("timeout_s6_pulse", 200);
      cycles(8);
      lit("s6_code_before", key_code, 6);
      lit("s6_held_before", key_held, 1);
      p0 = pulse_cnt;
      rst = 1'b1;
      pressed[1][2] = 1'b0;
      cycles(1);
      r_col = col_out; r_code = key_code; r_valid = key_valid; r_held = key_held;
      rst = 1'b0;
      lit("s6_rst_held", r_held, 0);
      lit("s6_rst_code", r_code, 0);
      lit("s6_rst_col", r_col, 4'b1110);
      lit("s6_rst_valid", r_valid, 0);
      cycles(20);
      lit("s6_no_pulse", pulse_cnt - p0, 0);

      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
